// File: rtl/sar_search_4bit_if.sv
// Comparator-side bundle for the SAR search engine: start request, B operand out, g/e/l flags in,
// and the held search report (result, compare count, error).
interface sar_search_4bit_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic             g;
  logic             e;
  logic             l;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;
  logic [CW-1:0]    cmp_cnt;

  // master: the search engine that produces the operand and consumes the flags
  modport master (
    input  start, g, e, l,
    output guess, busy, done, result, err, cmp_cnt
  );

  // slave: the requester/comparator side
  modport slave (
    output start, g, e, l,
    input  guess, busy, done, result, err, cmp_cnt
  );
endinterface

// File: rtl/sar_search_4bit.sv
// Successive-approximation search: drives guess to a comparator, resolves the target in at most
// WIDTH compares (LAT cycles each), then pulses done with result, compare count and error flag.
module sar_search_4bit #(
  parameter int WIDTH = 4,
  parameter int LAT   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sar_search_4bit_if.master  cmp_if
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = (LAT > 1) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cmp_cnt_q, cmp_cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             flags_onehot;
  logic [WIDTH-1:0] upd;

  assign flags_onehot = ( cmp_if.g & ~cmp_if.e & ~cmp_if.l) |
                        (~cmp_if.g &  cmp_if.e & ~cmp_if.l) |
                        (~cmp_if.g & ~cmp_if.e &  cmp_if.l);

  always_comb begin
    state_d   = state_q;
    guess_d   = guess_q;
    result_d  = result_q;
    cmp_cnt_d = cmp_cnt_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    upd       = guess_q;

    case (state_q)
      S_IDLE: begin
        if (cmp_if.start) begin
          idx_d     = IW'(WIDTH - 1);
          guess_d   = {1'b1, {(WIDTH-1){1'b0}}};
          result_d  = '0;
          err_d     = 1'b0;
          cmp_cnt_d = '0;
          cnt_d     = TW'(LAT);
          state_d   = S_WAIT;
          busy_d    = 1'b1;
        end
      end

      S_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q == TW'(1)) begin
          cmp_cnt_d = cmp_cnt_q + CW'(1);
          if (!flags_onehot) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = S_DONE;
          end else if (cmp_if.e) begin
            result_d = guess_q;
            state_d  = S_DONE;
          end else begin
            // l means the target is below the guess, so the trial bit is dropped
            if (cmp_if.l) upd[idx_q] = 1'b0;
            if (idx_q == '0) begin
              guess_d  = upd;
              result_d = upd;
              state_d  = S_DONE;
            end else begin
              upd[idx_q - IW'(1)] = 1'b1;
              guess_d = upd;
              idx_d   = idx_q - IW'(1);
              cnt_d   = TW'(LAT);
            end
          end
          if (state_d == S_DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      guess_q   <= '0;
      result_q  <= '0;
      cmp_cnt_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      guess_q   <= guess_d;
      result_q  <= result_d;
      cmp_cnt_q <= cmp_cnt_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cmp_if.guess   = guess_q;
  assign cmp_if.result  = result_q;
  assign cmp_if.cmp_cnt = cmp_cnt_q;
  assign cmp_if.err     = err_q;
  assign cmp_if.busy    = busy_q;
  assign cmp_if.done    = done_q;
endmodule

// File: tb/tb_sar_search_4bit.sv
// Bench for sar_search_4bit: comparator modelled as A=target, B=guess; table-driven searches
// plus hand-written sequences for error flags, mid-search reset, held start and LAT=3.
module tb_sar_search_4bit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sar_search_4bit_if #(.WIDTH(4)) if1 ();
  sar_search_4bit_if #(.WIDTH(4)) if3 ();

  sar_search_4bit #(.WIDTH(4), .LAT(1)) dut  (.clk_i(clk), .rst_i(rst), .cmp_if(if1));
  sar_search_4bit #(.WIDTH(4), .LAT(3)) dut3 (.clk_i(clk), .rst_i(rst), .cmp_if(if3));

  logic [3:0] tgt1, tgt3;
  logic       frc;
  logic [2:0] frc_gel;

  assign if1.g = frc ? frc_gel[2] : (tgt1 >  if1.guess);
  assign if1.e = frc ? frc_gel[1] : (tgt1 == if1.guess);
  assign if1.l = frc ? frc_gel[0] : (tgt1 <  if1.guess);
  assign if3.g = (tgt3 >  if3.guess);
  assign if3.e = (tgt3 == if3.guess);
  assign if3.l = (tgt3 <  if3.guess);

  logic       sel;
  logic       m_busy, m_done, m_err;
  logic [3:0] m_guess, m_result;
  logic [2:0] m_cnt;
  assign m_busy   = sel ? if3.busy    : if1.busy;
  assign m_done   = sel ? if3.done    : if1.done;
  assign m_err    = sel ? if3.err     : if1.err;
  assign m_guess  = sel ? if3.guess   : if1.guess;
  assign m_result = sel ? if3.result  : if1.result;
  assign m_cnt    = sel ? if3.cmp_cnt : if1.cmp_cnt;

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  r_res, r_guess;
  logic [2:0]  r_cnt;
  logic        r_err;
  int          r_cyc;
  logic [15:0] r_seq;

  // Pulses start for one edge (or holds it through busy), then follows the search to done.
  task automatic run(input logic s, input logic [3:0] t, input logic hold);
    logic       have;
    logic [3:0] last;
    sel = s;
    if (s) begin tgt3 = t; if3.start = 1'b1; end
    else   begin tgt1 = t; if1.start = 1'b1; end
    step();
    if (!hold) begin if1.start = 1'b0; if3.start = 1'b0; end
    r_cyc = 0; r_seq = '0; have = 1'b0; last = '0;
    while (!m_done && r_cyc < 60) begin
      if (m_busy && (!have || m_guess != last)) begin
        r_seq = {r_seq[11:0], m_guess};
        last  = m_guess;
        have  = 1'b1;
      end
      step();
      r_cyc++;
    end
    if1.start = 1'b0; if3.start = 1'b0;
    if (!m_done) begin
      check("done_timeout", 32'(r_cyc), 32'd60 + 32'd1);
    end
    r_res = m_result; r_cnt = m_cnt; r_err = m_err; r_guess = m_guess;
    check("busy_at_done", 32'(m_busy), 32'd0);
    step();
    check("done_one_cycle", 32'(m_done), 32'd0);
  endtask

  function automatic int ncmp(input int t);
    int gs = 8;
    int n = 0;
    for (int i = 3; i >= 0; i--) begin
      n++;
      if (gs == t) return n;
      if (t < gs) gs &= ~(1 << i);
      if (i > 0) gs |= (1 << (i - 1));
    end
    return n;
  endfunction

  typedef struct {
    logic [3:0]  tgt;
    logic [3:0]  res;
    logic [2:0]  cnt;
    logic        err;
    int          cyc;
    logic [15:0] seq;
    logic [3:0]  fin;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd5,  4'd5,  3'd4, 1'b0, 4, 16'h8465, 4'd5};
    vecs[1] = '{4'd8,  4'd8,  3'd1, 1'b0, 1, 16'h0008, 4'd8};
    vecs[2] = '{4'd0,  4'd0,  3'd4, 1'b0, 4, 16'h8421, 4'd0};
    vecs[3] = '{4'd15, 4'd15, 3'd4, 1'b0, 4, 16'h8CEF, 4'd15};
    vecs[4] = '{4'd7,  4'd7,  3'd4, 1'b0, 4, 16'h8467, 4'd7};
    vecs[5] = '{4'd12, 4'd12, 3'd2, 1'b0, 2, 16'h008C, 4'd12};

    rst = 1'b1; sel = 1'b0; frc = 1'b0; frc_gel = '0;
    tgt1 = '0; tgt3 = '0; if1.start = 1'b0; if3.start = 1'b0;
    repeat (3) step();
    check("rst_guess",  32'(if1.guess),   32'd0);
    check("rst_result", 32'(if1.result),  32'd0);
    check("rst_cnt",    32'(if1.cmp_cnt), 32'd0);
    check("rst_busy",   32'(if1.busy),    32'd0);
    check("rst_done",   32'(if1.done),    32'd0);
    check("rst_err",    32'(if1.err),     32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      run(1'b0, vecs[i].tgt, 1'b0);
      check($sformatf("vec%0d_result", i), 32'(r_res),   32'(vecs[i].res));
      check($sformatf("vec%0d_cnt", i),    32'(r_cnt),   32'(vecs[i].cnt));
      check($sformatf("vec%0d_err", i),    32'(r_err),   32'(vecs[i].err));
      check($sformatf("vec%0d_cycles", i), 32'(r_cyc),   32'(vecs[i].cyc));
      check($sformatf("vec%0d_seq", i),    32'(r_seq),   32'(vecs[i].seq));
      check($sformatf("vec%0d_guess", i),  32'(r_guess), 32'(vecs[i].fin));
    end

    // flags g and e together on the first compare
    frc = 1'b1; frc_gel = 3'b110;
    run(1'b0, 4'd5, 1'b0);
    check("err_ge_err",    32'(r_err), 32'd1);
    check("err_ge_result", 32'(r_res), 32'd0);
    check("err_ge_cnt",    32'(r_cnt), 32'd1);
    check("err_ge_cycles", 32'(r_cyc), 32'd1);
    frc_gel = 3'b000;
    run(1'b0, 4'd9, 1'b0);
    check("err_none_err", 32'(r_err), 32'd1);
    check("err_none_cnt", 32'(r_cnt), 32'd1);
    frc = 1'b0;
    run(1'b0, 4'd9, 1'b0);
    check("err_clear_err",    32'(r_err), 32'd0);
    check("err_clear_result", 32'(r_res), 32'd9);

    // reset landing on the second WAIT cycle of target=7
    sel = 1'b0; tgt1 = 4'd7; if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    step();
    check("pre_rst_busy", 32'(if1.busy),    32'd1);
    check("pre_rst_cnt",  32'(if1.cmp_cnt), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy",   32'(if1.busy),    32'd0);
    check("midrst_done",   32'(if1.done),    32'd0);
    check("midrst_guess",  32'(if1.guess),   32'd0);
    check("midrst_result", 32'(if1.result),  32'd0);
    check("midrst_cnt",    32'(if1.cmp_cnt), 32'd0);
    check("midrst_err",    32'(if1.err),     32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_no_done", 32'({if1.done, if1.busy}), 32'd0);
    end
    run(1'b0, 4'd7, 1'b0);
    check("restart_result", 32'(r_res), 32'd7);
    check("restart_cnt",    32'(r_cnt), 32'd4);

    // start held high through busy must not restart the search
    run(1'b0, 4'd5, 1'b1);
    check("hold_result", 32'(r_res), 32'd5);
    check("hold_cnt",    32'(r_cnt), 32'd4);
    check("hold_cycles", 32'(r_cyc), 32'd4);
    check("hold_idle",   32'(if1.busy), 32'd0);

    // LAT=3 instance
    run(1'b1, 4'd0, 1'b0);
    check("lat3_t0_cycles", 32'(r_cyc), 32'd12);
    check("lat3_t0_result", 32'(r_res), 32'd0);
    check("lat3_t0_cnt",    32'(r_cnt), 32'd4);
    check("lat3_t0_seq",    32'(r_seq), 32'h8421);
    run(1'b1, 4'd10, 1'b0);
    check("lat3_t10_cycles", 32'(r_cyc), 32'd9);
    check("lat3_t10_result", 32'(r_res), 32'd10);
    check("lat3_t10_cnt",    32'(r_cnt), 32'd3);

    for (int t = 0; t < 16; t++) begin
      run(1'b0, 4'(t), 1'b0);
      check($sformatf("sweep%0d_result", t), 32'(r_res), 32'(t));
      check($sformatf("sweep%0d_cnt", t),    32'(r_cnt), 32'(ncmp(t)));
      check($sformatf("sweep%0d_cycles", t), 32'(r_cyc), 32'(ncmp(t)));
      check($sformatf("sweep%0d_err", t),    32'(r_err), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
